seqmul: RTL and testbench
=========================

Name: seqmul

Overview:
Sequential shift-add multiplier; the inverse of the phase divider.
- Takes a 9-bit phase/quotient (fraction of 256) and a 19-bit frequency-table value.
- Produces count = (mplier * mcand) >> 8, i.e. it maps a phase back into oscillator count space.
- Sits between the frequency table and the oscillator/phase-offset logic in the SaSS voice path.
- Uses a start/done handshake that mirrors the divider's sample/done pair.

Parameters:
- None. Widths are fixed: mcand 19, mplier 9, accumulator 28, result 19.

Ports:
- clk  input  1  system clock; all state on rising edge
- RST  input  1  reset; one clock; reset is synchronous and active-high
- start  input  1  single-cycle pulse; captures operands and begins a multiply
- mcand  input  19  multiplicand (frequency-table value)
- mplier  input  9  multiplier (phase/quotient, 256 = 1.0)
- product_out  output  19  registered result, saturated (mplier*mcand)>>8
- busy  output  1  high while iterating
- done  output  1  high while product_out is valid for the last accepted start
- mcand_m  output  19  registered copy of captured mcand (debug/observe)
- mplier_m  output  9  registered copy of captured mplier (debug/observe)

Behaviour:
Reset:
- RST=1 at a clock edge forces state IDLE and clears acc, C, product_out, mcand_m, mplier_m, busy and done to 0.
- RST has priority over start at the same edge.

States: IDLE, RUN, DONE.
- Any state, start=1 at edge E0:
  - mcand_m <= mcand, mplier_m <= mplier.
  - acc <= 0, C <= 0, product_out <= 0, done <= 0.
  - state <= RUN.
  - start in RUN aborts the current operation and restarts with the new operands. No partial result is ever exposed.
- RUN, iteration C = 0..8 at each edge:
  - acc <= acc + (mplier_m[C] ? ({9'b0,mcand_m} << C) : 0).
  - C <= C + 1.
- RUN with C == 8, same edge as the last add:
  - state <= DONE.
  - product_out <= final_acc[27] ? 19'h7FFFF : final_acc[26:8].
- DONE:
  - done = 1; product_out, mcand_m and mplier_m hold.
  - Stays in DONE until start or RST. There is no auto-return to IDLE.
- IDLE: done = 0, busy = 0, product_out holds its value (0 after reset).

Outputs by state:
- busy = (state == RUN).
- done = (state == DONE).
- Both are decoded from the state register, so they are glitch-free.

Latency:
- Start sampled at E0; iterations occur at E1..E9.
- done and busy-low appear after E9, i.e. exactly 9 cycles after the start edge.
- Latency is fixed and independent of the operand values; there is no early exit on a zero multiplier.

Arithmetic:
- Unsigned.
- The 28-bit accumulator never overflows: the maximum is 511*524287 = 267,910,657 < 2^28.
- Truncation, not rounding.
- Saturation is applied only when bit 27 of the final sum is set.

Operand stability:
- mcand and mplier are don't-care except at the start edge; internal copies are used throughout.

Test Plan:
1. Reset, then start with mplier=9'h080, mcand=1000 -> busy high for 9 cycles; done rises 9 cycles after the start edge; product_out=500.
2. start with mplier=256, mcand=12345 -> product_out=12345. Then start with mplier=3, mcand=100 -> product_out=1 (truncation), done drops for 9 cycles in between.
3. start with mplier=9'h1FF, mcand=19'h7FFFF -> product_out=19'h7FFFF (saturated, raw 1,046,526). Then mplier=0, mcand=19'h7FFFF -> product_out=0 after 9 cycles.
4. Start mplier=200, mcand=5000; 4 cycles later start mplier=64, mcand=800 -> no done between the two; done 9 cycles after the second start; product_out=200, mcand_m=800.
5. Start mplier=255, mcand=4096; assert RST 5 cycles later -> next cycle all outputs 0, state IDLE; done stays 0 after RST drops until a new start.
6. RST and start both high on the same edge -> reset wins (outputs 0, busy=0). Holding DONE for 20 cycles -> product_out and done remain stable throughout.

Source files
------------

// File: rtl/seqmul.sv
// seqmul: sequential shift-add multiplier, the inverse of the phase divider.
// Maps a phase/quotient (fraction of 256) back into oscillator count space:
//   product_out = saturate19((mplier * mcand) >> 8)
// One multiplier bit is consumed per clock.  Latency is a fixed 9 cycles from
// the start edge, with no early exit.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   RST          synchronous active-high reset; takes priority over start
//   start        single-cycle pulse; captures operands and (re)starts a multiply
//   mcand        19-bit multiplicand (frequency-table value)
//   mplier       9-bit multiplier (phase, 256 = 1.0)
//   product_out  registered, saturated result
//   busy         high while iterating (state RUN)
//   done         high while product_out is valid for the last accepted start
//   mcand_m      captured multiplicand (observe)
//   mplier_m     captured multiplier (observe)
module seqmul (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic [18:0] mcand,
    input  logic [8:0]  mplier,
    output logic [18:0] product_out,
    output logic        busy,
    output logic        done,
    output logic [18:0] mcand_m,
    output logic [8:0]  mplier_m
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [27:0] acc_q;
    logic [3:0]  cnt_q;

    logic        mbit;
    logic [27:0] addend;
    logic [27:0] acc_sum;

    // Select the current multiplier bit without indexing past bit 8.
    always_comb begin
        mbit = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (cnt_q == 4'(i)) mbit = mplier_m[i];
        end
    end

    always_comb begin
        addend  = mbit ? ({9'b0, mcand_m} << cnt_q) : 28'd0;
        acc_sum = acc_q + addend;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_out <= '0;
            mcand_m     <= '0;
            mplier_m    <= '0;
        end else if (start) begin
            // Start in any state, including RUN, aborts and restarts.
            state_q     <= StRun;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_out <= '0;
            mcand_m     <= mcand;
            mplier_m    <= mplier;
        end else begin
            unique case (state_q)
                StRun: begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd8) begin
                        state_q     <= StDone;
                        // Bit 27 set means the shifted result exceeds 19 bits.
                        product_out <= acc_sum[27] ? 19'h7FFFF : acc_sum[26:8];
                    end
                end
                StIdle, StDone: ;  // hold until start or RST
                default: state_q <= StIdle;
            endcase
        end
    end

    // Decoded straight from the state register, so glitch-free.
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_seqmul.sv
module tb_seqmul;

    logic        clk;
    logic        RST;
    logic        start;
    logic [18:0] mcand;
    logic [8:0]  mplier;
    logic [18:0] product_out;
    logic        busy;
    logic        done;
    logic [18:0] mcand_m;
    logic [8:0]  mplier_m;

    int total;
    int passed;

    seqmul dut (
        .clk         (clk),
        .RST         (RST),
        .start       (start),
        .mcand       (mcand),
        .mplier      (mplier),
        .product_out (product_out),
        .busy        (busy),
        .done        (done),
        .mcand_m     (mcand_m),
        .mplier_m    (mplier_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive start for one edge; returns just after that edge (at the negedge).
    task automatic do_start(input logic [8:0] m, input logic [18:0] c);
        start  = 1'b1;
        mplier = m;
        mcand  = c;
        @(negedge clk);
        start  = 1'b0;
        // Operands are don't-care after the start edge.
        mplier = ~m;
        mcand  = ~c;
    endtask

    // Count cycles from the start edge until done, bounded.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n), 32'd9);
    endtask

    initial begin
        int seen;
        total  = 0;
        passed = 0;
        RST    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);

        // 1. reset state, then 0.5 * 1000
        check("rst_product", 32'(product_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mcand_m", 32'(mcand_m), 32'd0);
        do_start(9'h080, 19'd1000);
        check("t1_mcand_m", 32'(mcand_m), 32'd1000);
        check("t1_mplier_m", 32'(mplier_m), 32'h080);
        for (int k = 0; k < 9; k++) begin
            check("t1_busy_run", 32'(busy), 32'd1);
            check("t1_done_run", 32'(done), 32'd0);
            check("t1_product_hidden", 32'(product_out), 32'd0);
            @(negedge clk);
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_product", 32'(product_out), 32'd500);

        // 2. unity gain, then truncation
        do_start(9'd256, 19'd12345);
        wait_done("t2a_latency");
        check("t2a_product", 32'(product_out), 32'd12345);
        do_start(9'd3, 19'd100);
        check("t2b_done_dropped", 32'(done), 32'd0);
        wait_done("t2b_latency");
        check("t2b_product", 32'(product_out), 32'd1);

        // 3. saturation, then zero multiplier (no early exit)
        do_start(9'h1FF, 19'h7FFFF);
        wait_done("t3a_latency");
        check("t3a_product_sat", 32'(product_out), 32'h7FFFF);
        check("t3a_mcand_m", 32'(mcand_m), 32'h7FFFF);
        do_start(9'd0, 19'h7FFFF);
        wait_done("t3b_latency");
        check("t3b_product", 32'(product_out), 32'd0);

        // 4. restart mid-run
        do_start(9'd200, 19'd5000);
        seen = 0;
        repeat (3) begin
            if (done) seen++;
            @(negedge clk);
        end
        do_start(9'd64, 19'd800);
        wait_done("t4_latency");
        check("t4_no_early_done", 32'(seen), 32'd0);
        check("t4_product", 32'(product_out), 32'd200);
        check("t4_mcand_m", 32'(mcand_m), 32'd800);
        check("t4_mplier_m", 32'(mplier_m), 32'd64);

        // 5. reset during run
        do_start(9'd255, 19'd4096);
        repeat (4) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        check("t5_product", 32'(product_out), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_mcand_m", 32'(mcand_m), 32'd0);
        check("t5_mplier_m", 32'(mplier_m), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("t5_stays_idle", 32'(seen), 32'd0);

        // 6. RST beats start; DONE holds
        RST    = 1'b1;
        start  = 1'b1;
        mplier = 9'd100;
        mcand  = 19'd777;
        @(negedge clk);
        RST   = 1'b0;
        start = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_mcand_m", 32'(mcand_m), 32'd0);
        check("t6_product", 32'(product_out), 32'd0);
        do_start(9'h080, 19'd1000);
        wait_done("t6_latency");
        seen = 0;
        repeat (20) begin
            if (!done || product_out != 19'd500 || mcand_m != 19'd1000) seen++;
            @(negedge clk);
        end
        check("t6_hold_stable", 32'(seen), 32'd0);
        check("t6_product_final", 32'(product_out), 32'd500);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
